// File: rtl/rx_mac_to_buffer.sv
// rx_mac_to_buffer: writes MAC frames into the RX qword buffer as {length header, data qwords}
// and publishes the commit pointer only after a whole good frame and its header are stored.
module rx_mac_to_buffer #(
  parameter int BF = 9,
  parameter int MAX_FRAME_QW = 1200
) (
  input  logic          clk156,
  input  logic          reset,
  input  logic [63:0]   s_axis_tdata,
  input  logic [7:0]    s_axis_tkeep,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  input  logic          s_axis_tuser,
  input  logic [BF+1:0] commited_rd_address,
  output logic [BF:0]   wr_addr,
  output logic [63:0]   wr_data,
  output logic          wr_en,
  output logic [BF+1:0] commited_wr_address,
  output logic [31:0]   frames_ok,
  output logic [31:0]   frames_dropped
);
  localparam int PW = BF + 2;
  localparam logic [PW-1:0] DEPTH = {1'b1, {(BF+1){1'b0}}};
  localparam logic [2:0] IDLE = 3'd0, DATA = 3'd1, HDR = 3'd2, CMT = 3'd3, DROP = 3'd4;
  logic [2:0] state;
  logic [PW-1:0] wr_ptr, occ, ptr1;
  logic [BF:0] hdr_ptr;
  logic [15:0] len, qw;
  logic [3:0] bytes;
  logic drop_pend, viol, no_room, stop;
  always_comb begin
    occ = wr_ptr - commited_rd_address;
    ptr1 = wr_ptr + PW'(1);
    no_room = occ >= DEPTH - PW'(1);
    stop = (occ == DEPTH) || (qw == 16'(MAX_FRAME_QW));
    bytes = 4'($countones(s_axis_tkeep));
  end
  // Outside a frame wr_ptr always equals the commit pointer, so CMT can start the next frame from wr_ptr
  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      hdr_ptr <= '0;
      len <= '0;
      qw <= '0;
      drop_pend <= 1'b0;
      viol <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_en <= 1'b0;
      commited_wr_address <= '0;
      frames_ok <= '0;
      frames_dropped <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, CMT: begin
          if (state == CMT) begin
            commited_wr_address <= wr_ptr;
            frames_ok <= frames_ok + 32'd1;
          end
          state <= IDLE;
          viol <= 1'b0;
          if (s_axis_tvalid && viol) state <= s_axis_tlast ? IDLE : DROP;
          else if (s_axis_tvalid && no_room) begin
            state <= s_axis_tlast ? IDLE : DROP;
            drop_pend <= !s_axis_tlast;
            if (s_axis_tlast) frames_dropped <= frames_dropped + 32'd1;
          end else if (s_axis_tvalid) begin
            hdr_ptr <= wr_ptr[BF:0];
            wr_en <= 1'b1;
            wr_addr <= ptr1[BF:0];
            wr_data <= s_axis_tdata;
            len <= 16'(bytes);
            qw <= 16'd1;
            if (s_axis_tlast && s_axis_tuser) frames_dropped <= frames_dropped + 32'd1;
            else begin
              wr_ptr <= wr_ptr + PW'(2);
              state <= s_axis_tlast ? HDR : DATA;
            end
          end
        end
        DATA: if (s_axis_tvalid) begin
          if (!stop) begin
            wr_en <= 1'b1;
            wr_addr <= wr_ptr[BF:0];
            wr_data <= s_axis_tdata;
            len <= len + 16'(bytes);
            qw <= qw + 16'd1;
          end
          if (stop || (s_axis_tlast && s_axis_tuser)) begin
            wr_ptr <= commited_wr_address;
            frames_dropped <= frames_dropped + 32'd1;
            drop_pend <= 1'b0;
            state <= s_axis_tlast ? IDLE : DROP;
          end else begin
            wr_ptr <= ptr1;
            if (s_axis_tlast) state <= HDR;
          end
        end
        HDR: begin
          wr_en <= 1'b1;
          wr_addr <= hdr_ptr;
          wr_data <= {48'h0, len};
          state <= CMT;
          // A beat arriving here breaks the IFG contract: count it now, swallow the rest of it after commit
          if (s_axis_tvalid) begin
            frames_dropped <= frames_dropped + 32'd1;
            viol <= !s_axis_tlast;
            drop_pend <= 1'b0;
          end
        end
        DROP: if (s_axis_tvalid && s_axis_tlast) begin
          state <= IDLE;
          drop_pend <= 1'b0;
          if (drop_pend) frames_dropped <= frames_dropped + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_mac_to_buffer.sv
// tb_rx_mac_to_buffer: frame-level model of the RX buffer writer checked every cycle, plus literal checks.
module tb_rx_mac_to_buffer;
  localparam int BF = 9;
  localparam int DEPTH = 1024;
  localparam int MOD = 2048;
  logic clk156 = 1'b0, reset = 1'b0;
  logic [63:0] tdata = '0;
  logic [7:0] tkeep = '0;
  logic tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0, big = 1'b0;
  logic [BF+1:0] rd = '0;
  logic [BF:0] wr_addr;
  logic [63:0] wr_data;
  logic wr_en;
  logic [BF+1:0] cwa;
  logic [31:0] frames_ok, frames_dropped;
  logic [10:0] big_wr_addr;
  logic [63:0] big_wr_data;
  logic big_wr_en;
  logic [11:0] big_cwa;
  logic [31:0] big_ok, big_drop;
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  bit armed = 1'b0;
  int m_cwa = 0, m_ok = 0, m_drop = 0;
  logic [BF+1:0] exp_cwa = '0;
  logic [31:0] exp_ok = '0, exp_drop = '0;
  logic [BF+1:0] s_cwa [int];
  logic [31:0] s_ok [int];
  logic [31:0] s_drop [int];
  logic [BF:0] s_waddr [int];
  logic [63:0] s_wdata [int];
  logic [63:0] mem_img [DEPTH];
  int big_writes = 0;
  logic [63:0] big_hdr0 = '0;

  always #5 clk156 = ~clk156;
  always @(posedge clk156) cyc <= cyc + 1;

  rx_mac_to_buffer #(.BF(BF), .MAX_FRAME_QW(1200)) dut (
    .clk156(clk156), .reset(reset), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
    .s_axis_tvalid(tvalid & !big), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .commited_rd_address(rd), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .commited_wr_address(cwa), .frames_ok(frames_ok), .frames_dropped(frames_dropped));

  rx_mac_to_buffer #(.BF(10), .MAX_FRAME_QW(1200)) dut_big (
    .clk156(clk156), .reset(reset), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
    .s_axis_tvalid(tvalid & big), .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .commited_rd_address(12'd0), .wr_addr(big_wr_addr), .wr_data(big_wr_data), .wr_en(big_wr_en),
    .commited_wr_address(big_cwa), .frames_ok(big_ok), .frames_dropped(big_drop));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk156);
    if (armed) begin
      if (s_cwa.exists(cyc)) exp_cwa = s_cwa[cyc];
      if (s_ok.exists(cyc)) exp_ok = s_ok[cyc];
      if (s_drop.exists(cyc)) exp_drop = s_drop[cyc];
      chk("wr_en", 64'(wr_en), 64'(s_waddr.exists(cyc)));
      if (s_waddr.exists(cyc)) begin
        chk("wr_addr", 64'(wr_addr), 64'(s_waddr[cyc]));
        chk("wr_data", wr_data, s_wdata[cyc]);
      end
      chk("commited_wr_address", 64'(cwa), 64'(exp_cwa));
      chk("frames_ok", 64'(frames_ok), 64'(exp_ok));
      chk("frames_dropped", 64'(frames_dropped), 64'(exp_drop));
      if (wr_en) mem_img[wr_addr] = wr_data;
      if (big_wr_en) begin
        big_writes++;
        if (big_wr_addr == 11'd0) big_hdr0 = big_wr_data;
      end
    end
  end

  task automatic hard_reset();
    reset = 1'b1;
    tvalid = 1'b0;
    tlast = 1'b0;
    tuser = 1'b0;
    rd = '0;
    s_cwa.delete();
    s_ok.delete();
    s_drop.delete();
    s_waddr.delete();
    s_wdata.delete();
    m_cwa = 0;
    m_ok = 0;
    m_drop = 0;
    exp_cwa = '0;
    exp_ok = '0;
    exp_drop = '0;
    big_writes = 0;
    for (int i = 0; i < DEPTH; i++) mem_img[i] = '1;
    #2;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_cwa", 64'(cwa), 64'd0);
    chk("rst_ok", 64'(frames_ok), 64'd0);
    chk("rst_drop", 64'(frames_dropped), 64'd0);
    repeat (2) @(posedge clk156);
    #1 reset = 1'b0;
  endtask

  // Frame-level expectation: which beats land where, and when the drop or the commit becomes visible
  task automatic model_frame(input int t0, input int n, input logic [7:0] lk, input bit bad, input int fid);
    int c, r, d;
    c = m_cwa;
    r = int'(rd);
    if (DEPTH - (((c - r) % MOD + MOD) % MOD) < 2) begin
      m_drop++;
      s_drop[t0 + n] = 32'(m_drop);
      return;
    end
    d = n;
    for (int i = 1; i < n; i++)
      if (d == n && (i == 1200 || (((c + 1 + i - r) % MOD + MOD) % MOD) == DEPTH)) d = i;
    for (int i = 0; i < d; i++) begin
      s_waddr[t0 + i + 1] = 10'((c + 1 + i) % DEPTH);
      s_wdata[t0 + i + 1] = {32'(fid), 32'(i)};
    end
    if (d < n || bad) begin
      m_drop++;
      s_drop[d < n ? t0 + d + 1 : t0 + n] = 32'(m_drop);
    end else begin
      s_waddr[t0 + n + 1] = 10'(c % DEPTH);
      s_wdata[t0 + n + 1] = 64'(8 * (n - 1) + $countones(lk));
      m_cwa = (c + 1 + n) % MOD;
      m_ok++;
      s_cwa[t0 + n + 2] = 11'(m_cwa);
      s_ok[t0 + n + 2] = 32'(m_ok);
    end
  endtask

  task automatic send(input int n, input logic [7:0] lk, input bit bad, input int fid, input int cut);
    int t0;
    @(posedge clk156);
    #1;
    t0 = cyc;
    if (!big) model_frame(t0, n, lk, bad, fid);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk156);
        #1;
      end
      if (cut != 0 && i == cut) begin
        hard_reset();
        return;
      end
      tdata = {32'(fid), 32'(i)};
      tkeep = (i == n - 1) ? lk : 8'hFF;
      tlast = (i == n - 1);
      tuser = bad && (i == n - 1);
      tvalid = 1'b1;
    end
    @(posedge clk156);
    #1;
    tvalid = 1'b0;
    tlast = 1'b0;
    tuser = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
  endtask

  initial begin
    #1;
    hard_reset();
    armed = 1'b1;
    // 60-byte frame: 7 full beats plus a 4-byte tail
    send(8, 8'h0F, 1'b0, 1, 0);
    chk("t1_cwa", 64'(cwa), 64'd9);
    chk("t1_ok", 64'(frames_ok), 64'd1);
    chk("t1_hdr", mem_img[0], 64'h3C);
    chk("t1_last", mem_img[8], {32'd1, 32'd7});
    chk("t1_model_cwa", 64'(m_cwa), 64'd9);
    // bad frame is rewound, next good frame reuses addr 0
    @(posedge clk156);
    #1;
    hard_reset();
    send(8, 8'h0F, 1'b1, 2, 0);
    chk("t2_cwa", 64'(cwa), 64'd0);
    chk("t2_drop", 64'(frames_dropped), 64'd1);
    chk("t2_no_hdr", mem_img[0], 64'hFFFF_FFFF_FFFF_FFFF);
    send(8, 8'h0F, 1'b0, 3, 0);
    chk("t2_hdr", mem_img[0], 64'h3C);
    chk("t2_cwa_good", 64'(cwa), 64'd9);
    chk("t2_ok", 64'(frames_ok), 64'd1);
    // overflow near the top of the buffer
    @(posedge clk156);
    #1;
    hard_reset();
    send(1019, 8'hFF, 1'b0, 30, 0);
    chk("t3_fill_cwa", 64'(cwa), 64'd1020);
    send(10, 8'hFF, 1'b0, 31, 0);
    chk("t3_ovf_cwa", 64'(cwa), 64'd1020);
    chk("t3_ovf_drop", 64'(frames_dropped), 64'd1);
    chk("t3_ovf_last_written", mem_img[1023], {32'd31, 32'd2});
    rd = 11'd1020;
    send(1, 8'hFF, 1'b0, 32, 0);
    chk("t3_next_cwa", 64'(cwa), 64'd1022);
    chk("t3_next_hdr", mem_img[1020], 64'd8);
    chk("t3_ok", 64'(frames_ok), 64'd2);
    // pointer wrap
    rd = 11'd1022;
    send(1023, 8'hFF, 1'b0, 40, 0);
    chk("t4_pre_cwa", 64'(cwa), 64'd2046);
    rd = 11'd2046;
    send(3, 8'hFF, 1'b0, 41, 0);
    chk("t4_cwa", 64'(cwa), 64'd2);
    chk("t4_model_cwa", 64'(m_cwa), 64'd2);
    chk("t4_hdr", mem_img[1022], 64'h18);
    chk("t4_d0", mem_img[1023], {32'd41, 32'd0});
    chk("t4_d1", mem_img[0], {32'd41, 32'd1});
    chk("t4_d2", mem_img[1], {32'd41, 32'd2});
    chk("t4_ok", 64'(frames_ok), 64'd4);
    // reset at beat 3 of a frame, then a fresh frame from address 0
    send(10, 8'hFF, 1'b0, 50, 3);
    send(2, 8'hFF, 1'b0, 51, 0);
    chk("t5_hdr", mem_img[0], 64'd16);
    chk("t5_cwa", 64'(cwa), 64'd3);
    chk("t5_ok", 64'(frames_ok), 64'd1);
    // oversize on a buffer deep enough to hold a maximum frame
    big = 1'b1;
    send(1201, 8'hFF, 1'b0, 60, 0);
    chk("t6_over_cwa", 64'(big_cwa), 64'd0);
    chk("t6_over_drop", 64'(big_drop), 64'd1);
    chk("t6_over_ok", 64'(big_ok), 64'd0);
    chk("t6_over_writes", 64'(big_writes), 64'd1200);
    send(1200, 8'hFF, 1'b0, 61, 0);
    chk("t6_max_cwa", 64'(big_cwa), 64'd1201);
    chk("t6_max_ok", 64'(big_ok), 64'd1);
    chk("t6_max_drop", 64'(big_drop), 64'd1);
    chk("t6_max_writes", 64'(big_writes), 64'd2401);
    chk("t6_max_hdr", big_hdr0, 64'd9600);
    big = 1'b0;
    repeat (3) @(posedge clk156);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
